// File: rtl/ctrl_hazard_pipe.sv
// rtl/ctrl_hazard_pipe.sv - control-side E/M/W pipeline with load-use, redirect and forwarding logic
// Holds the staged control bundle only; the datapath registers follow StallF/StallD/FlushD/FlushE.
module ctrl_hazard_pipe #(
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RegWriteD,
    input  logic [1:0]        ResultSrcD,
    input  logic              MemWriteD,
    input  logic              JumpD,
    input  logic [1:0]        BranchD,
    input  logic              ALUSrcD,
    input  logic              sel_adderD,
    input  logic [4:0]        Rs1D,
    input  logic [4:0]        Rs2D,
    input  logic [4:0]        RdD,
    input  logic              ZeroE,
    output logic              RegWriteE,
    output logic              RegWriteM,
    output logic              RegWriteW,
    output logic [1:0]        ResultSrcE,
    output logic [1:0]        ResultSrcM,
    output logic [1:0]        ResultSrcW,
    output logic              MemWriteE,
    output logic              MemWriteM,
    output logic              ALUSrcE,
    output logic              sel_adderE,
    output logic [4:0]        RdE,
    output logic [4:0]        RdM,
    output logic [4:0]        RdW,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic              PCSrcE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic [PERF_W-1:0] stall_count,
    output logic [PERF_W-1:0] flush_count
);

    localparam logic [PERF_W-1:0] CNT_MAX = '1;

    logic       jump_e;
    logic [1:0] branch_e;
    logic [4:0] rs1_e;
    logic [4:0] rs2_e;
    logic       lw_stall;

    // A flushed D->E load becomes a bubble: no write, no store, no jump, no branch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWriteE  <= 1'b0;
            ResultSrcE <= 2'b00;
            MemWriteE  <= 1'b0;
            jump_e     <= 1'b0;
            branch_e   <= 2'b00;
            ALUSrcE    <= 1'b0;
            sel_adderE <= 1'b0;
            rs1_e      <= 5'd0;
            rs2_e      <= 5'd0;
            RdE        <= 5'd0;
        end else if (FlushE) begin
            RegWriteE  <= 1'b0;
            ResultSrcE <= 2'b00;
            MemWriteE  <= 1'b0;
            jump_e     <= 1'b0;
            branch_e   <= 2'b00;
            ALUSrcE    <= 1'b0;
            sel_adderE <= 1'b0;
            rs1_e      <= 5'd0;
            rs2_e      <= 5'd0;
            RdE        <= 5'd0;
        end else begin
            RegWriteE  <= RegWriteD;
            ResultSrcE <= ResultSrcD;
            MemWriteE  <= MemWriteD;
            jump_e     <= JumpD;
            branch_e   <= BranchD;
            ALUSrcE    <= ALUSrcD;
            sel_adderE <= sel_adderD;
            rs1_e      <= Rs1D;
            rs2_e      <= Rs2D;
            RdE        <= RdD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWriteM  <= 1'b0;
            ResultSrcM <= 2'b00;
            MemWriteM  <= 1'b0;
            RdM        <= 5'd0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            RdW        <= 5'd0;
        end else begin
            RegWriteM  <= RegWriteE;
            ResultSrcM <= ResultSrcE;
            MemWriteM  <= MemWriteE;
            RdM        <= RdE;
            RegWriteW  <= RegWriteM;
            ResultSrcW <= ResultSrcM;
            RdW        <= RdM;
        end
    end

    always_comb begin
        PCSrcE   = jump_e | ((branch_e == 2'b01) & ZeroE) | ((branch_e == 2'b10) & ~ZeroE);
        lw_stall = RegWriteE & (ResultSrcE == 2'b01) & (RdE != 5'd0) &
                   ((RdE == Rs1D) | (RdE == Rs2D));
        // A redirect squashes the D instruction, so there is nothing left to stall for.
        StallF   = lw_stall & ~PCSrcE;
        StallD   = lw_stall & ~PCSrcE;
        FlushD   = PCSrcE;
        FlushE   = lw_stall | PCSrcE;

        ForwardAE = 2'b00;
        if (RegWriteM && RdM != 5'd0 && RdM == rs1_e)
            ForwardAE = 2'b10;
        else if (RegWriteW && RdW != 5'd0 && RdW == rs1_e)
            ForwardAE = 2'b01;

        ForwardBE = 2'b00;
        if (RegWriteM && RdM != 5'd0 && RdM == rs2_e)
            ForwardBE = 2'b10;
        else if (RegWriteW && RdW != 5'd0 && RdW == rs2_e)
            ForwardBE = 2'b01;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (StallF && stall_count != CNT_MAX)
                stall_count <= stall_count + PERF_W'(1);
            if (PCSrcE && flush_count != CNT_MAX)
                flush_count <= flush_count + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_ctrl_hazard_pipe.sv
// tb/tb_ctrl_hazard_pipe.sv - directed scoreboard bench for ctrl_hazard_pipe
module tb_ctrl_hazard_pipe;

    localparam int PW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          RegWriteD = 1'b0;
    logic [1:0]    ResultSrcD = 2'b00;
    logic          MemWriteD = 1'b0;
    logic          JumpD = 1'b0;
    logic [1:0]    BranchD = 2'b00;
    logic          ALUSrcD = 1'b0;
    logic          sel_adderD = 1'b0;
    logic [4:0]    Rs1D = 5'd0;
    logic [4:0]    Rs2D = 5'd0;
    logic [4:0]    RdD = 5'd0;
    logic          ZeroE = 1'b0;
    logic          RegWriteE, RegWriteM, RegWriteW;
    logic [1:0]    ResultSrcE, ResultSrcM, ResultSrcW;
    logic          MemWriteE, MemWriteM, ALUSrcE, sel_adderE;
    logic [4:0]    RdE, RdM, RdW;
    logic          StallF, StallD, FlushD, FlushE, PCSrcE;
    logic [1:0]    ForwardAE, ForwardBE;
    logic [PW-1:0] stall_count, flush_count;

    ctrl_hazard_pipe #(.PERF_W(PW)) dut (
        .clk(clk), .rst_n(rst_n),
        .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
        .JumpD(JumpD), .BranchD(BranchD), .ALUSrcD(ALUSrcD), .sel_adderD(sel_adderD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ZeroE(ZeroE),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .ResultSrcM(ResultSrcM), .ResultSrcW(ResultSrcW),
        .MemWriteE(MemWriteE), .MemWriteM(MemWriteM),
        .ALUSrcE(ALUSrcE), .sel_adderE(sel_adderE),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .PCSrcE(PCSrcE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    typedef enum {
        REGWRITE_E, REGWRITE_M, REGWRITE_W, RESULTSRC_E, MEMWRITE_E, MEMWRITE_M,
        ALUSRC_E, SELADDER_E, RD_E, RD_M, RD_W, STALL_F, STALL_D, FLUSH_D, FLUSH_E,
        PCSRC_E, FWD_A, FWD_B, STALL_CNT, FLUSH_CNT
    } sig_t;

    typedef struct {
        int   cyc;
        sig_t sig;
        int   val;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] dut_val(sig_t s);
        case (s)
            REGWRITE_E:  return 32'(RegWriteE);
            REGWRITE_M:  return 32'(RegWriteM);
            REGWRITE_W:  return 32'(RegWriteW);
            RESULTSRC_E: return 32'(ResultSrcE);
            MEMWRITE_E:  return 32'(MemWriteE);
            MEMWRITE_M:  return 32'(MemWriteM);
            ALUSRC_E:    return 32'(ALUSrcE);
            SELADDER_E:  return 32'(sel_adderE);
            RD_E:        return 32'(RdE);
            RD_M:        return 32'(RdM);
            RD_W:        return 32'(RdW);
            STALL_F:     return 32'(StallF);
            STALL_D:     return 32'(StallD);
            FLUSH_D:     return 32'(FlushD);
            FLUSH_E:     return 32'(FlushE);
            PCSRC_E:     return 32'(PCSrcE);
            FWD_A:       return 32'(ForwardAE);
            FWD_B:       return 32'(ForwardBE);
            STALL_CNT:   return 32'(stall_count);
            FLUSH_CNT:   return 32'(flush_count);
            default:     return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: at each falling edge, check every expectation queued for this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                tests++;
                if (e.cyc != cyc) begin
                    fails++;
                    $display("FAIL %s stale expectation cyc=%0d now=%0d expected=%0d",
                             e.sig.name(), e.cyc, cyc, e.val);
                end else if (dut_val(e.sig) !== 32'(e.val)) begin
                    fails++;
                    $display("FAIL %s cyc=%0d actual=%0d expected=%0d",
                             e.sig.name(), cyc, dut_val(e.sig), e.val);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic ex(input sig_t s, input int v);
        q.push_back('{cyc, s, v});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setd(input logic rw, input logic [1:0] rs, input logic mw, input logic j,
                        input logic [1:0] br, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd);
        RegWriteD  = rw;
        ResultSrcD = rs;
        MemWriteD  = mw;
        JumpD      = j;
        BranchD    = br;
        Rs1D       = r1;
        Rs2D       = r2;
        RdD        = rd;
        ALUSrcD    = 1'b0;
        sel_adderD = 1'b0;
    endtask

    task automatic dz();
        setd(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0);
    endtask

    initial begin
        // Reset held: even with a jump presented in D, everything reads 0.
        step(); setd(1'b1, 2'b01, 1'b1, 1'b1, 2'b01, 5'd1, 5'd2, 5'd3);
        ex(REGWRITE_E, 0); ex(PCSRC_E, 0); ex(STALL_F, 0); ex(FLUSH_E, 0);
        ex(FWD_A, 0); ex(STALL_CNT, 0); ex(FLUSH_CNT, 0); ex(RD_W, 0);
        step(); rst_n = 1'b1; dz();
        ex(REGWRITE_E, 0); ex(RD_E, 0);

        // Latency: E +1, M +2, W +3.
        step(); setd(1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd7);
        ALUSrcD = 1'b1; sel_adderD = 1'b1;
        ex(REGWRITE_E, 0);
        step(); dz();
        ex(RD_E, 7); ex(REGWRITE_E, 1); ex(ALUSRC_E, 1); ex(SELADDER_E, 1); ex(RD_M, 0);
        step(); ex(RD_M, 7); ex(REGWRITE_M, 1); ex(RD_E, 0);
        step(); ex(RD_W, 7); ex(REGWRITE_W, 1); ex(RD_M, 0);

        // Load-use: lw x5 then add x6, x5.
        step(); setd(1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd5);
        step(); setd(1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 5'd5, 5'd0, 5'd6);
        ex(STALL_F, 1); ex(STALL_D, 1); ex(FLUSH_E, 1); ex(FLUSH_D, 0); ex(PCSRC_E, 0);
        ex(RESULTSRC_E, 1); ex(STALL_CNT, 0);
        step();
        ex(REGWRITE_E, 0); ex(STALL_F, 0); ex(FLUSH_E, 0); ex(STALL_CNT, 1);
        ex(REGWRITE_M, 1); ex(RD_M, 5);
        step(); dz();
        ex(REGWRITE_E, 1); ex(RD_E, 6); ex(FWD_A, 1); ex(FWD_B, 0);

        // lw x0 followed by a reader of x0: never a stall.
        step(); setd(1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0);
        step(); setd(1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd4);
        ex(STALL_F, 0); ex(FLUSH_E, 0);

        // Forwarding priority: add x3, add x3, consumer of x3 on both operands.
        step(); setd(1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd3);
        step();
        step(); setd(1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 5'd3, 5'd3, 5'd9);
        step(); setd(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 5'd3, 5'd0, 5'd0);
        ex(FWD_A, 2); ex(FWD_B, 2);
        step(); dz();
        ex(FWD_A, 1); ex(FWD_B, 0);

        // Writes to x0 in M and W with Rs1E=Rs2E=0: no forwarding.
        step(); setd(1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0);
        step();
        step(); dz();
        step();
        ex(FWD_A, 0); ex(FWD_B, 0); ex(REGWRITE_M, 1); ex(REGWRITE_W, 1);

        // Branches.
        step(); setd(1'b0, 2'b00, 1'b0, 1'b0, 2'b01, 5'd0, 5'd0, 5'd0); ZeroE = 1'b1;
        step(); dz();
        ex(PCSRC_E, 1); ex(FLUSH_D, 1); ex(FLUSH_E, 1); ex(STALL_F, 0); ex(FLUSH_CNT, 0);
        step(); setd(1'b0, 2'b00, 1'b0, 1'b0, 2'b10, 5'd0, 5'd0, 5'd0);
        ex(FLUSH_CNT, 1); ex(PCSRC_E, 0);
        step();
        ex(PCSRC_E, 0); ex(FLUSH_D, 0);
        step(); dz(); ZeroE = 1'b0;
        ex(PCSRC_E, 1); ex(FLUSH_E, 1); ex(FLUSH_CNT, 1);
        step(); setd(1'b0, 2'b00, 1'b0, 1'b0, 2'b11, 5'd0, 5'd0, 5'd0);
        ex(FLUSH_CNT, 2); ex(PCSRC_E, 0);
        step(); ZeroE = 1'b1;
        ex(PCSRC_E, 0);
        step(); dz(); ZeroE = 1'b0;
        ex(PCSRC_E, 0); ex(FLUSH_CNT, 2);

        // Jump that also looks like a load to the following instruction.
        step(); setd(1'b1, 2'b01, 1'b0, 1'b1, 2'b00, 5'd0, 5'd0, 5'd5);
        step(); setd(1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 5'd5, 5'd0, 5'd6);
        ex(PCSRC_E, 1); ex(STALL_F, 0); ex(STALL_D, 0); ex(FLUSH_D, 1); ex(FLUSH_E, 1);
        ex(STALL_CNT, 1);
        step(); setd(1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 5'd0, 5'd0, 5'd0);
        ex(FLUSH_CNT, 3); ex(STALL_CNT, 1); ex(REGWRITE_E, 0);
        step(); dz();
        ex(PCSRC_E, 1);
        step(); setd(1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0);
        ex(FLUSH_CNT, 3);

        // Store staging.
        step(); dz();
        ex(MEMWRITE_E, 1);
        step(); setd(1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 5'd5, 5'd0, 5'd5);
        ex(MEMWRITE_M, 1); ex(MEMWRITE_E, 0);

        // Self-dependent load held in D: stalls every other cycle, counter saturates at 3.
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 1) ex(STALL_F, 1);
            if (i == 2) begin
                ex(STALL_F, 0);
                ex(STALL_CNT, 2);
            end
            if (i == 4) ex(STALL_CNT, 3);
            if (i == 10) ex(STALL_CNT, 3);
        end

        // Asynchronous reset mid-stream, checked before any clock edge.
        step(); #1 rst_n = 1'b0;
        ex(REGWRITE_E, 0); ex(RD_E, 0); ex(RESULTSRC_E, 0); ex(STALL_F, 0); ex(FLUSH_E, 0);
        ex(STALL_CNT, 0); ex(FLUSH_CNT, 0); ex(RD_M, 0);
        step(); rst_n = 1'b1; dz();
        ex(REGWRITE_E, 0); ex(REGWRITE_M, 0);
        step();
        ex(REGWRITE_M, 0); ex(REGWRITE_W, 0); ex(MEMWRITE_M, 0); ex(STALL_CNT, 0);

        step();
        step();
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL leftover_expectations actual=%0d expected=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ctrl_hazard_pipe.md
Name: ctrl_hazard_pipe

Overview:
- Consumes the decode-stage control bundle produced by the opcode decoder and carries it through the E, M and W pipeline stages.
- Detects load-use and control hazards and drives stall/flush, PCSrcE and forwarding selects for the 5-stage RV32I pipeline.
- Sits between the decoder output and the datapath pipeline registers; holds the control-side pipeline state only.
- Also keeps saturating stall and flush performance counters.

Parameters:
- PERF_W, 16, width of the stall_count and flush_count performance counters.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous reset, active-low
- RegWriteD  in  1  decode control bit
- ResultSrcD  in  2  00 ALU, 01 memory (load), 10 PC+4
- MemWriteD  in  1  decode control bit
- JumpD  in  1  decode control bit
- BranchD  in  2  01 take-if-zero (beq), 10 take-if-nonzero, 00 none
- ALUSrcD  in  1  decode control bit
- sel_adderD  in  1  1 = jalr target base is rs1
- Rs1D, Rs2D, RdD  in  5 each  decode register indices
- ZeroE  in  1  ALU zero flag from the execute stage
- RegWriteE/M/W  out  1 each  staged control
- ResultSrcE/M/W  out  2 each  staged control
- MemWriteE/M  out  1 each  staged control
- ALUSrcE, sel_adderE  out  1 each  staged control
- RdE/M/W  out  5 each  staged destination index
- StallF, StallD  out  1 each  hold the PC and IF/ID registers
- FlushD, FlushE  out  1 each  bubble IF/ID and ID/EX
- PCSrcE  out  1  redirect the PC
- ForwardAE, ForwardBE  out  2 each  00 register file, 10 from M, 01 from W
- stall_count, flush_count  out  PERF_W each  performance counters

Behaviour:
- Reset (rst_n=0, asynchronous): every staged register clears to 0, which includes Rs1E, Rs2E, JumpE, BranchE, RdE/M/W and both counters. All outputs read 0 during reset and after it.
- D->E register:
  - Loads every clock when FlushE=0.
  - Loads all zeros when FlushE=1, giving a bubble with no write, no memory access, no jump and no branch.
  - Rs1E and Rs2E are staged internally with the other D->E fields.
- E->M and M->W registers: advance every clock with no stall and no flush.
- Latency: a D-stage bundle appears on the E outputs after 1 clock, M after 2 and W after 3.
- Branch and jump resolution (combinational, E stage):
  - PCSrcE = JumpE | (BranchE==01 & ZeroE) | (BranchE==10 & ~ZeroE).
  - BranchE==11 is treated as 00.
- Load-use detection (combinational): lwStall = RegWriteE & ResultSrcE==01 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
- Stall and flush outputs:
  - StallF = StallD = lwStall & ~PCSrcE. A redirect wins, because the instruction in D is being squashed anyway.
  - FlushD = PCSrcE.
  - FlushE = lwStall | PCSrcE.
- Forwarding for operand A:
  - ForwardAE = 10 when RegWriteM & RdM!=0 & RdM==Rs1E.
  - Otherwise 01 when RegWriteW & RdW!=0 & RdW==Rs1E.
  - Otherwise 00.
  - The M stage has priority over W when both match.
- Forwarding for operand B: same rules as ForwardAE, using Rs2E.
- x0 is never stalled on and never forwarded.
- Counters:
  - stall_count increments on each clock where StallF=1.
  - flush_count increments on each clock where PCSrcE=1.
  - Both saturate at 2^PERF_W-1 and never wrap.
- Reset asserted mid-stream: in-flight control clears immediately. No write or store is issued from pre-reset state after rst_n rises.

Test Plan:
- Load-use: lw x5 in E (ResultSrcE=01, RdE=5, RegWriteE=1) with Rs1D=5 -> StallF=StallD=FlushE=1 for exactly 1 cycle; next cycle RegWriteE=0 (bubble); stall_count=1.
- Forwarding priority: add x3 in M, add x3 in W, Rs1E=3 -> ForwardAE=10; with M retired and only W matching -> 01; with Rd=0 in both -> 00.
- Branch: BranchE=01 with ZeroE=1 -> PCSrcE=FlushD=FlushE=1; BranchE=10 with ZeroE=1 -> PCSrcE=0; BranchE=10 with ZeroE=0 -> PCSrcE=1; flush_count increments per taken branch.
- Simultaneous: JumpE=1, and the E instruction also matches lwStall conditions -> StallF=StallD=0, FlushD=FlushE=1.
- Pipeline latency: RegWriteD=1, RdD=7 -> RdE=7 at +1 clock, RdM=7 at +2, RdW=7 at +3 with RegWriteW=1.
- Reset/saturation: PERF_W=2 with 5 stall cycles -> stall_count=3 and held; assert rst_n=0 mid-sequence -> all outputs 0 without waiting for a clock edge.
